// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation encoding,
// FSM states and timing constants. MDU_MADD_EN adds the multiply-accumulate ops.
package mult_div_unit_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned DIV_CYCLES = 33;
    localparam int unsigned CNT_W      = 6;

    typedef enum logic [3:0] {
        MDU_READ_HI            = 4'd0,
        MDU_READ_LO            = 4'd1,
        MDU_WRITE_HI           = 4'd2,
        MDU_WRITE_LO           = 4'd3,
        MDU_START_SIGNED_MUL   = 4'd4,
        MDU_START_UNSIGNED_MUL = 4'd5,
        MDU_START_SIGNED_DIV   = 4'd6,
        MDU_START_UNSIGNED_DIV = 4'd7
`ifdef MDU_MADD_EN
        ,
        MDU_START_SIGNED_MADD   = 4'd8,
        MDU_START_UNSIGNED_MADD = 4'd9,
        MDU_START_SIGNED_MSUB   = 4'd10,
        MDU_START_UNSIGNED_MSUB = 4'd11
`endif
    } MduOperation;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

`ifdef MDU_MADD_EN
    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_SUB  = 2'd2
    } mdu_acc_e;
`endif

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring radix-2 divider: 32 quotient-bit iterations followed by
// one sign-fix cycle during which done is high and the signed results are valid.
module mdu_divider
    import mult_div_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic              is_signed,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero
);

    localparam int unsigned ITER_W = 5;

    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;
    logic [ITER_W-1:0] iter_q;
    logic              running_q;
    logic              neg_quo_q;
    logic              neg_rem_q;

    logic [DATA_W-1:0] dividend_mag_c;
    logic [DATA_W-1:0] divisor_mag_c;
    logic [DATA_W:0]   shifted_c;
    logic [DATA_W+1:0] diff_c;
    logic [DATA_W-1:0] rem_next_c;
    logic [DATA_W-1:0] quo_next_c;

    // Operand magnitudes for the unsigned core
    always_comb begin
        dividend_mag_c = (is_signed && dividend[DATA_W-1]) ? (DATA_W'(0) - dividend) : dividend;
        divisor_mag_c  = (is_signed && divisor[DATA_W-1])  ? (DATA_W'(0) - divisor)  : divisor;
    end

    // One restoring step: shift in the next dividend bit and trial-subtract
    always_comb begin
        shifted_c  = {rem_q, quo_q[DATA_W-1]};
        diff_c     = {1'b0, shifted_c} - {2'b00, dvs_q};
        rem_next_c = shifted_c[DATA_W-1:0];
        quo_next_c = {quo_q[DATA_W-2:0], 1'b0};
        if (!diff_c[DATA_W+1]) begin
            rem_next_c = diff_c[DATA_W-1:0];
            quo_next_c = {quo_q[DATA_W-2:0], 1'b1};
        end
    end

    // Iteration state; done marks the sign-fix cycle after the last iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            iter_q      <= '0;
            running_q   <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (start) begin
            rem_q       <= '0;
            quo_q       <= dividend_mag_c;
            dvs_q       <= divisor_mag_c;
            iter_q      <= '0;
            running_q   <= 1'b1;
            neg_quo_q   <= is_signed && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
            neg_rem_q   <= is_signed && dividend[DATA_W-1];
            done        <= 1'b0;
            div_by_zero <= (divisor == '0);
        end else if (running_q) begin
            rem_q  <= rem_next_c;
            quo_q  <= quo_next_c;
            iter_q <= iter_q + ITER_W'(1);
            if (iter_q == ITER_W'(DATA_W - 1)) begin
                running_q <= 1'b0;
                done      <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    // Sign fix: quotient truncates toward zero, remainder follows the dividend
    always_comb begin
        quotient  = neg_quo_q ? (DATA_W'(0) - quo_q) : quo_q;
        remainder = neg_rem_q ? (DATA_W'(0) - rem_q) : rem_q;
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulate operations.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] operand1,
    input  logic [DATA_W-1:0] operand2,
    input  MduOperation       operation,
    input  logic              start,
    output logic              busy,
    output logic [DATA_W-1:0] data_read
);

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

    mdu_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [2*DATA_W-1:0] prod_q;
    logic                mul_load_c;
    logic                mul_signed_c;
    logic                div_start_c;
    logic [2*DATA_W-1:0] ext_a_c;
    logic [2*DATA_W-1:0] ext_b_c;
    logic [2*DATA_W-1:0] prod_c;

    logic                div_done;
    logic                div_by_zero;
    logic [DATA_W-1:0]   div_quotient;
    logic [DATA_W-1:0]   div_remainder;

`ifdef MDU_MADD_EN
    mdu_acc_e            acc_q;
    mdu_acc_e            acc_c;
`endif

    mdu_divider u_divider (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (div_start_c),
        .dividend    (operand1),
        .divisor     (operand2),
        .is_signed   (operation == MDU_START_SIGNED_DIV),
        .done        (div_done),
        .quotient    (div_quotient),
        .remainder   (div_remainder),
        .div_by_zero (div_by_zero)
    );

    // Signedness and accumulate mode of the requested multiply
    always_comb begin
        mul_signed_c = (operation == MDU_START_SIGNED_MUL);
`ifdef MDU_MADD_EN
        acc_c = ACC_NONE;
        unique case (operation)
            MDU_START_SIGNED_MADD:   begin mul_signed_c = 1'b1; acc_c = ACC_ADD; end
            MDU_START_UNSIGNED_MADD: acc_c = ACC_ADD;
            MDU_START_SIGNED_MSUB:   begin mul_signed_c = 1'b1; acc_c = ACC_SUB; end
            MDU_START_UNSIGNED_MSUB: acc_c = ACC_SUB;
            default: ;
        endcase
`endif
    end

    // Full 64-bit product; sign- or zero-extension makes one multiplier serve both
    always_comb begin
        ext_a_c = mul_signed_c ? {{DATA_W{operand1[DATA_W-1]}}, operand1} : {DATA_W'(0), operand1};
        ext_b_c = mul_signed_c ? {{DATA_W{operand2[DATA_W-1]}}, operand2} : {DATA_W'(0), operand2};
        prod_c  = ext_a_c * ext_b_c;
    end

    // Next-state, counter and HI/LO update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        mul_load_c  = 1'b0;
        div_start_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    unique case (operation)
                        MDU_START_SIGNED_MUL,
`ifdef MDU_MADD_EN
                        MDU_START_SIGNED_MADD,
                        MDU_START_UNSIGNED_MADD,
                        MDU_START_SIGNED_MSUB,
                        MDU_START_UNSIGNED_MSUB,
`endif
                        MDU_START_UNSIGNED_MUL: begin
                            state_d    = ST_MUL;
                            cnt_d      = '0;
                            mul_load_c = 1'b1;
                        end
                        MDU_START_SIGNED_DIV,
                        MDU_START_UNSIGNED_DIV: begin
                            state_d     = ST_DIV;
                            cnt_d       = '0;
                            div_start_c = 1'b1;
                        end
                        MDU_WRITE_HI: hi_d = operand1;
                        MDU_WRITE_LO: lo_d = operand1;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (cnt_q == MUL_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
`ifdef MDU_MADD_EN
                    unique case (acc_q)
                        ACC_ADD: {hi_d, lo_d} = {hi_q, lo_q} + prod_q;
                        ACC_SUB: {hi_d, lo_d} = {hi_q, lo_q} - prod_q;
                        default: {hi_d, lo_d} = prod_q;
                    endcase
`else
                    {hi_d, lo_d} = prod_q;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DIV: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (div_done && !div_by_zero) begin
                        hi_d = div_remainder;
                        lo_d = div_quotient;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter, HI/LO and busy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy    <= (state_d != ST_IDLE);
        end
    end

    // Multiplier result register, captured when a multiply is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
`ifdef MDU_MADD_EN
            acc_q  <= ACC_NONE;
`endif
        end else if (mul_load_c) begin
            prod_q <= prod_c;
`ifdef MDU_MADD_EN
            acc_q  <= acc_c;
`endif
        end
    end

    // Zero-latency HI/LO read port
    always_comb begin
        data_read = '0;
        unique case (operation)
            MDU_READ_HI: data_read = hi_q;
            MDU_READ_LO: data_read = lo_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (MDU_MADD_EN adds accumulate vectors).
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] operand1;
    logic [31:0] operand2;
    MduOperation operation;
    logic        start;
    logic        busy;
    logic [31:0] data_read;

    int tests_run    = 0;
    int tests_failed = 0;

    mult_div_unit #(.MUL_LATENCY(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .operand1  (operand1),
        .operand2  (operand2),
        .operation (operation),
        .start     (start),
        .busy      (busy),
        .data_read (data_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic read_reg(input MduOperation op, output logic [31:0] val);
        operation = op;
        #1;
        val = data_read;
    endtask

    task automatic issue(input MduOperation op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        operation = op;
        operand1  = a;
        operand2  = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        operation = MDU_READ_HI;
    endtask

    // Counts falling edges with busy high; leaves time at the first idle falling edge
    task automatic wait_idle(output int cycles);
        cycles = 0;
        @(negedge clk);
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        if (cycles >= 100) check_eq("busy_timeout", 32'(cycles), 32'd0);
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] v;
        read_reg(MDU_READ_HI, v);
        check_eq({tag, "_hi"}, v, exp_hi);
        read_reg(MDU_READ_LO, v);
        check_eq({tag, "_lo"}, v, exp_lo);
    endtask

    initial begin
        int          n;
        logic [31:0] v;

        rst_n     = 1'b0;
        start     = 1'b0;
        operand1  = '0;
        operand2  = '0;
        operation = MDU_READ_HI;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_hilo("reset", 32'h0, 32'h0);
        read_reg(MDU_WRITE_HI, v);
        check_eq("nonread_op_zero", v, 32'h0);

        // Signed multiply
        issue(MDU_START_SIGNED_MUL, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_idle(n);
        check_eq("mult_cycles", 32'(n), 32'd5);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // Unsigned multiply
        issue(MDU_START_UNSIGNED_MUL, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_idle(n);
        check_eq("multu_cycles", 32'(n), 32'd5);
        check_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        // Signed divide, with an MTHI attempt and a read while busy
        issue(MDU_START_SIGNED_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        check_eq("div_busy_rise", 32'(busy), 32'd1);
        issue(MDU_WRITE_HI, 32'h0000_1234, 32'h0);
        read_reg(MDU_READ_HI, v);
        check_eq("div_read_while_busy", v, 32'h0000_0001);
        wait_idle(n);
        check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // Unsigned divide, full latency
        issue(MDU_START_UNSIGNED_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_idle(n);
        check_eq("divu_cycles", 32'(n), 32'd33);
        check_hilo("divu", 32'h0000_0001, 32'h7FFF_FFFC);

        // Signed overflow case
        issue(MDU_START_SIGNED_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check_hilo("div_ovf", 32'h0000_0000, 32'h8000_0000);

        // MTLO while idle
        issue(MDU_WRITE_LO, 32'h0000_ABCD, 32'h0);
        @(negedge clk);
        check_eq("mtlo_busy", 32'(busy), 32'd0);
        read_reg(MDU_READ_LO, v);
        check_eq("mtlo_lo", v, 32'h0000_ABCD);

        // Divide by zero leaves HI/LO untouched
        issue(MDU_WRITE_HI, 32'h0000_0011, 32'h0);
        issue(MDU_WRITE_LO, 32'h0000_0022, 32'h0);
        issue(MDU_START_UNSIGNED_DIV, 32'h0000_0005, 32'h0000_0000);
        wait_idle(n);
        check_eq("div0_cycles", 32'(n), 32'd33);
        check_hilo("div0", 32'h0000_0011, 32'h0000_0022);

`ifdef MDU_MADD_EN
        // Accumulate carries from LO into HI, then subtract borrows back
        issue(MDU_WRITE_HI, 32'h0000_0000, 32'h0);
        issue(MDU_WRITE_LO, 32'hFFFF_FFFF, 32'h0);
        issue(MDU_START_UNSIGNED_MADD, 32'h0000_0001, 32'h0000_0001);
        wait_idle(n);
        check_eq("maddu_cycles", 32'(n), 32'd5);
        check_hilo("maddu", 32'h0000_0001, 32'h0000_0000);
        issue(MDU_START_UNSIGNED_MSUB, 32'h0000_0001, 32'h0000_0001);
        wait_idle(n);
        check_hilo("msubu", 32'h0000_0000, 32'hFFFF_FFFF);
        issue(MDU_START_SIGNED_MADD, 32'hFFFF_FFFF, 32'h0000_0003);
        wait_idle(n);
        check_hilo("madd", 32'h0000_0000, 32'hFFFF_FFFC);
`endif

        // Reset in the middle of a divide
        issue(MDU_WRITE_HI, 32'h0000_0055, 32'h0);
        issue(MDU_START_UNSIGNED_DIV, 32'h0000_0064, 32'h0000_0003);
        repeat (10) @(negedge clk);
        check_eq("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("reset_mid_busy", 32'(busy), 32'd0);
        check_hilo("reset_mid", 32'h0, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("post_reset_busy", 32'(busy), 32'd0);
        check_hilo("post_reset", 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
